charge_trigger: RTL and testbench
=================================

CHARGE_TRIGGER -- requirements
Module: charge_trigger

Interface
REQ-001 Parameter: FAST_SIM, default 1'b0, SHALL select shortened timing for simulation.
REQ-002 Port: clk  input  1  system clock (50 MHz); the only clock.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: btn  input  1  raw, asynchronous, bouncing push-button level; high means pressed.
REQ-005 Port: go  output  1  single-cycle start pulse to the charge tune player.
REQ-006 Port: busy  output  1  high while a tune is deemed playing (FIRE and LOCKOUT states).
REQ-007 Port: trig_cnt  output  8  count of accepted triggers.

Function
REQ-008 btn SHALL pass through a 2-flop synchronizer; btn_s is the second flop; no other logic SHALL sample btn.
REQ-009 The FSM SHALL have exactly these states: IDLE, DEBOUNCE, FIRE, LOCKOUT, RELEASE.
REQ-010 One shared 26-bit counter SHALL time all states; it is cleared on every state entry and advances once per cycle otherwise.
REQ-011 Timing constants:
- FAST_SIM=0: DB_CYC = 1,048,576 (2^20); LOCK_CYC = 58,720,256 (7*2^23, the full tune length).
- FAST_SIM=1: DB_CYC = 65,536; LOCK_CYC = 3,670,016.
REQ-012 IDLE transitions:
- btn_s=1 -> DEBOUNCE.
- btn_s=0 -> remain in IDLE.
REQ-013 DEBOUNCE transitions:
- Any cycle with btn_s=0 -> IDLE.
- DB_CYC consecutive cycles with btn_s=1 -> FIRE.
REQ-014 FIRE SHALL last exactly one cycle, with go=1 during that cycle, then transition to LOCKOUT.
REQ-015 LOCKOUT SHALL last exactly LOCK_CYC cycles regardless of btn_s, then transition to RELEASE.
REQ-016 Any btn activity during LOCKOUT SHALL be ignored and SHALL NOT queue a trigger.
REQ-017 RELEASE transitions:
- Any btn_s=1 clears the counter.
- DB_CYC consecutive cycles with btn_s=0 -> IDLE.
- A button held through LOCKOUT therefore never retriggers.
REQ-018 go and busy SHALL be decoded from the state register only, so they are glitch-free.
- go=1 only in FIRE.
- busy=1 in FIRE and LOCKOUT.
REQ-019 Trigger latency:
- Edge 0 is the first edge sampling btn=1, with btn held steady afterwards.
- go SHALL be high in the cycle following edge DB_CYC+2.
REQ-020 No more than one go pulse SHALL occur per FIRE entry.
- Minimum spacing between go pulses = 1+LOCK_CYC+DB_CYC+1+DB_CYC cycles.
REQ-021 An unreachable state encoding SHALL return to IDLE on the next edge.

Reset
REQ-022 rst=1 SHALL immediately, without waiting for a clock edge, force:
- state=IDLE, counter=0, both synchronizer flops=0.
- go=0, busy=0, trig_cnt=0.
REQ-023 Reset asserted mid-DEBOUNCE or mid-LOCKOUT SHALL abort the operation without emitting go.
- After rst deasserts, a new press SHALL require the full debounce again.

Configuration
REQ-024 Macro CHARGE_TRIG_CNT_EN controls the trigger counter.
- Defined: trig_cnt SHALL increment by 1 on each FIRE cycle and saturate at 255.
- Undefined: trig_cnt SHALL be constant 8'h00, with no counter flops synthesized.

Verification
REQ-025 The bench SHALL cover these directed scenarios, with FAST_SIM=1 unless stated:
- Clean press, btn=1 held for 100,000 cycles -> exactly one go pulse, in the cycle after edge 65,538; busy high for 3,670,017 cycles.
- Bounce, btn toggling every 500 cycles for 20,000 cycles then low -> go never asserts; FSM back in IDLE.
- Short press then second press at cycle 1,000,000 (inside LOCKOUT) -> no second go; a third press after LOCKOUT plus release debounce -> second go.
- btn held high continuously for 5,000,000 cycles -> exactly one go; FSM stays in RELEASE until btn drops, then 65,536 low cycles -> IDLE.
- rst pulsed at cycle 2,000,000 during LOCKOUT -> busy falls without a clock edge; go=0; next press yields go exactly DB_CYC+2 edges after its first sample.
- 300 accepted triggers -> trig_cnt=255 with CHARGE_TRIG_CNT_EN defined, 0 without.

Source files
------------

// File: rtl/charge_trigger.sv
// charge_trigger: debounced push-button trigger for the charge tune player.
// A synchronized button press that stays stable for DB_CYC cycles produces
// one go pulse. A LOCK_CYC lockout covering the tune length follows, and
// then the button must stay released for DB_CYC cycles before it re-arms.
// Optional feature macro: CHARGE_TRIG_CNT_EN enables the saturating 8-bit
// trigger counter. When it is undefined, trig_cnt is tied to zero.
module charge_trigger #(
  parameter logic        FAST_SIM     = 1'b0,
  // A nonzero value overrides the FAST_SIM-selected timing so that a bench
  // can use very short windows. Zero keeps the standard table.
  parameter int unsigned DB_CYC_OVR   = 0,
  parameter int unsigned LOCK_CYC_OVR = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn,
  output logic       go,
  output logic       busy,
  output logic [7:0] trig_cnt
);

  localparam logic [25:0] DB_CYC =
    (DB_CYC_OVR != 0) ? 26'(DB_CYC_OVR)
                      : (FAST_SIM ? 26'd65536 : 26'd1048576);
  localparam logic [25:0] LOCK_CYC =
    (LOCK_CYC_OVR != 0) ? 26'(LOCK_CYC_OVR)
                        : (FAST_SIM ? 26'd3670016 : 26'd58720256);
  localparam logic [25:0] DB_LAST   = DB_CYC - 26'd1;
  localparam logic [25:0] LOCK_LAST = LOCK_CYC - 26'd1;

  // Bit 2 of the encoding marks the busy states, so busy is a single flop.
  // FIRE and LOCKOUT differ only in bit 1, so the go decode cannot glitch
  // when the FSM leaves FIRE.
  localparam logic [2:0] IDLE     = 3'b000;
  localparam logic [2:0] DEBOUNCE = 3'b001;
  localparam logic [2:0] RELEASE  = 3'b010;
  localparam logic [2:0] LOCKOUT  = 3'b100;
  localparam logic [2:0] FIRE     = 3'b110;

  logic        sync1_q;
  logic        btn_s_q;
  logic [2:0]  state_q, state_d;
  logic [25:0] cnt_q, cnt_d;

  // Two-flop synchronizer. Only this logic samples the raw button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= 1'b0;
      btn_s_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      btn_s_q <= sync1_q;
    end
  end

  // Next-state logic. The shared counter restarts on every state change.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 26'd1;
    case (state_q)
      IDLE: begin
        if (btn_s_q) state_d = DEBOUNCE;
      end
      DEBOUNCE: begin
        if (!btn_s_q)               state_d = IDLE;
        else if (cnt_q == DB_LAST)  state_d = FIRE;
      end
      FIRE: begin
        state_d = LOCKOUT;
      end
      LOCKOUT: begin
        // The button is deliberately ignored for the whole tune.
        if (cnt_q == LOCK_LAST) state_d = RELEASE;
      end
      RELEASE: begin
        // The release window restarts on any sign of the button. A press
        // held through the lockout therefore never retriggers.
        if (btn_s_q)                cnt_d   = '0;
        else if (cnt_q == DB_LAST)  state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // State and timer registers. Reset aborts any debounce or lockout at once.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign go   = (state_q == FIRE);
  assign busy = state_q[2];

`ifdef CHARGE_TRIG_CNT_EN
  logic [7:0] trig_cnt_q, trig_cnt_d;

  always_comb begin
    trig_cnt_d = trig_cnt_q;
    if ((state_q == FIRE) && (trig_cnt_q != 8'hFF)) trig_cnt_d = trig_cnt_q + 8'd1;
  end

  // Saturating count of accepted triggers, bumped once per FIRE cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) trig_cnt_q <= '0;
    else     trig_cnt_q <= trig_cnt_d;
  end

  assign trig_cnt = trig_cnt_q;
`else
  assign trig_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_charge_trigger.sv
// Directed bench for charge_trigger. It uses short timing windows (DB=8,
// LOCK=64) so that every scenario fits in a short run.
module tb_charge_trigger;

  localparam int DB   = 8;
  localparam int LOCK = 64;

  localparam logic [2:0] S_IDLE = 3'b000;
  localparam logic [2:0] S_DEB  = 3'b001;
  localparam logic [2:0] S_REL  = 3'b010;
  localparam logic [2:0] S_LOCK = 3'b100;
  localparam logic [2:0] S_FIRE = 3'b110;

  logic       clk = 1'b0;
  logic       rst;
  logic       btn;
  logic       go;
  logic       busy;
  logic [7:0] trig_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic       lvl;
    int         cycles;
    int         exp_go;
    int         exp_busy;
    bit         chk_state;
    logic [2:0] exp_state;
  } vec_t;

  vec_t vecs[$];

  always #10 clk = ~clk;

  charge_trigger #(
    .FAST_SIM    (1'b1),
    .DB_CYC_OVR  (DB),
    .LOCK_CYC_OVR(LOCK)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .btn     (btn),
    .go      (go),
    .busy    (busy),
    .trig_cnt(trig_cnt)
  );

  function automatic int exp_trig(input int n);
`ifdef CHARGE_TRIG_CNT_EN
    return (n > 255) ? 255 : n;
`else
    return 0;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Hold btn at lvl for n cycles. Count go and busy samples taken at each negedge.
  task automatic run(input logic lvl, input int n, output int gos, output int busys);
    btn   = lvl;
    gos   = 0;
    busys = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (go === 1'b1)   gos++;
      if (busy === 1'b1) busys++;
    end
  endtask

  // Pulse the reset between clock edges. Check that the outputs drop without an edge.
  task automatic pulse_rst(input string tag);
    #3 rst = 1'b1;
    #1;
    check({tag, "_busy_async"}, 32'(busy), 32'd0);
    check({tag, "_go_async"}, 32'(go), 32'd0);
    check({tag, "_state_async"}, 32'(dut.state_q), 32'(S_IDLE));
    check({tag, "_trig_async"}, 32'(trig_cnt), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
  endtask

  // With btn held high, find the first go sample index, bounded by n cycles.
  task automatic latency(input int n, output int first, output int cnt);
    first = -1;
    cnt   = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (go === 1'b1) begin
        if (first < 0) first = i;
        cnt++;
      end
    end
  endtask

  function automatic vec_t mk(input logic l, input int c, input int g, input int b,
                              input bit cs, input logic [2:0] st);
    vec_t v;
    v.lvl = l; v.cycles = c; v.exp_go = g; v.exp_busy = b;
    v.chk_state = cs; v.exp_state = st;
    return v;
  endfunction

  initial begin
    int g, b, g2, b2, first, cnt, total;

    // Clean press held long, then the exact release boundary.
    vecs.push_back(mk(1'b1, 100, 1, 65, 1, S_REL));
    vecs.push_back(mk(1'b0,   9, 0,  0, 1, S_REL));
    vecs.push_back(mk(1'b0,   1, 0,  0, 1, S_IDLE));
    // Bounce shorter than the debounce window.
    for (int k = 0; k < 5; k++) begin
      vecs.push_back(mk(1'b1, 4, 0, 0, 0, S_IDLE));
      vecs.push_back(mk(1'b0, 4, 0, 0, 0, S_IDLE));
    end
    vecs.push_back(mk(1'b0, 20, 0, 0, 1, S_IDLE));
    // Press of exactly DB cycles aborts. DB+1 cycles fires.
    vecs.push_back(mk(1'b1,   8, 0,  0, 1, S_DEB));
    vecs.push_back(mk(1'b0,  12, 0,  0, 1, S_IDLE));
    vecs.push_back(mk(1'b1,   9, 0,  0, 1, S_DEB));
    vecs.push_back(mk(1'b0, 100, 1, 65, 1, S_IDLE));
    // go appears exactly one cycle after edge DB+2.
    vecs.push_back(mk(1'b1,  10, 0,  0, 1, S_DEB));
    vecs.push_back(mk(1'b1,   1, 1,  1, 1, S_FIRE));
    vecs.push_back(mk(1'b1, 100, 0, 64, 1, S_REL));
    vecs.push_back(mk(1'b0,  10, 0,  0, 1, S_IDLE));
    // Short press, a second press inside the lockout, then a legitimate third press.
    vecs.push_back(mk(1'b1, 12, 1,  2, 1, S_LOCK));
    vecs.push_back(mk(1'b0, 20, 0, 20, 1, S_LOCK));
    vecs.push_back(mk(1'b1, 10, 0, 10, 1, S_LOCK));
    vecs.push_back(mk(1'b0, 60, 0, 33, 1, S_IDLE));
    vecs.push_back(mk(1'b1, 20, 1, 10, 1, S_LOCK));
    vecs.push_back(mk(1'b0, 80, 0, 55, 1, S_IDLE));

    rst = 1'b1;
    btn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_go", 32'(go), 32'd0);
    check("reset_busy", 32'(busy), 32'd0);
    check("reset_trig", 32'(trig_cnt), 32'd0);
    check("reset_state", 32'(dut.state_q), 32'(S_IDLE));
    rst = 1'b0;

    foreach (vecs[i]) begin
      run(vecs[i].lvl, vecs[i].cycles, g, b);
      check($sformatf("v%0d_go", i), 32'(g), 32'(vecs[i].exp_go));
      check($sformatf("v%0d_busy", i), 32'(b), 32'(vecs[i].exp_busy));
      if (vecs[i].chk_state)
        check($sformatf("v%0d_state", i), 32'(dut.state_q), 32'(vecs[i].exp_state));
    end

    // Reset in the middle of the lockout, with the button held through it.
    run(1'b1, 30, g, b);
    check("rl_pre_go", 32'(g), 32'd1);
    check("rl_pre_state", 32'(dut.state_q), 32'(S_LOCK));
    pulse_rst("rl");
    latency(41, first, cnt);
    check("rl_latency", 32'(first), 32'(DB + 2));
    check("rl_go_count", 32'(cnt), 32'd1);
    run(1'b0, 100, g, b);
    check("rl_tail_busy", 32'(b), 32'd34);
    check("rl_tail_state", 32'(dut.state_q), 32'(S_IDLE));

    // Reset in the middle of the debounce. No go, and the full debounce again.
    run(1'b1, 6, g, b);
    check("rd_pre_go", 32'(g), 32'd0);
    check("rd_pre_state", 32'(dut.state_q), 32'(S_DEB));
    pulse_rst("rd");
    latency(20, first, cnt);
    check("rd_latency", 32'(first), 32'(DB + 2));
    check("rd_go_count", 32'(cnt), 32'd1);
    run(1'b0, 100, g, b);
    check("rd_tail_busy", 32'(b), 32'd55);
    check("rd_tail_state", 32'(dut.state_q), 32'(S_IDLE));

    // 300 accepted triggers from a cleared counter.
    pulse_rst("tc");
    total = 0;
    for (int t = 1; t <= 300; t++) begin
      run(1'b1, 12, g, b);
      run(1'b0, 80, g2, b2);
      total += g + g2;
      if (t == 100 || t == 255)
        check($sformatf("trig_at_%0d", t), 32'(trig_cnt), 32'(exp_trig(t)));
    end
    check("trig_total_go", 32'(total), 32'd300);
    check("trig_final", 32'(trig_cnt), 32'(exp_trig(300)));
    check("trig_end_state", 32'(dut.state_q), 32'(S_IDLE));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
